// File: rtl/fp32_sub_normalize_seq.sv
// Multi-cycle normalise/round/pack stage that follows the FP32 mantissa subtract.
// Define FP32_SUB_ROUND_NEAREST_EN to build the round-to-nearest-even state; otherwise truncates.
module fp32_sub_normalize_seq #(
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [24:0] in_man,
    input  logic [2:0]  in_grs,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [2:0]  out_flags
);

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

`ifdef FP32_SUB_ROUND_NEAREST_EN
    typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_t;
`else
    typedef enum logic [1:0] {StIdle, StNorm, StDone} state_t;
`endif

    state_t      state_q;
    logic        sign_q;
    logic [7:0]  exp_q;
    logic [24:0] man_q;
    logic [2:0]  grs_q;

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] cnt;
        logic       found;
        cnt   = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      cnt = cnt + 5'd1;
            end
        end
        return cnt;
    endfunction

    logic [4:0]  lz;
    logic [4:0]  shamt;
    logic [26:0] shl;

    // Guard then round feed in from the bottom as the mantissa moves left.
    always_comb begin
        lz    = lzc24(man_q[23:0]);
        shamt = (lz > STEP) ? STEP : lz;
        shl   = {man_q, grs_q[2:1]} << shamt;
    end

`ifdef FP32_SUB_ROUND_NEAREST_EN
    logic        rnd_inc;
    logic [23:0] rnd_frac;

    // Hidden bit is always set in ROUND, so a carry out of the fraction means 2.0.
    always_comb begin
        rnd_inc  = grs_q[2] & (grs_q[1] | grs_q[0] | man_q[0]);
        rnd_frac = {1'b0, man_q[22:0]} + {23'd0, rnd_inc};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= 32'd0;
            out_flags  <= 3'd0;
            sign_q     <= 1'b0;
            exp_q      <= 8'd0;
            man_q      <= 25'd0;
            grs_q      <= 3'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        sign_q   <= in_sign;
                        exp_q    <= in_exp;
                        man_q    <= in_man;
                        grs_q    <= in_grs;
                        if (in_exp == 8'd0) begin
                            out_valid  <= 1'b1;
                            out_result <= 32'd0;
                            out_flags  <= {1'b0, (in_man != 25'd0), 1'b1};
                            state_q    <= StDone;
                        end else begin
                            state_q <= StNorm;
                        end
                    end
                end
                StNorm: begin
                    if (man_q == 25'd0 && grs_q == 3'd0) begin
                        out_valid  <= 1'b1;
                        out_result <= 32'd0;
                        out_flags  <= 3'b001;
                        state_q    <= StDone;
                    end else if (man_q[24]) begin
                        if (exp_q == 8'hFE) begin
                            out_valid  <= 1'b1;
                            out_result <= {sign_q, 8'hFF, 23'd0};
                            out_flags  <= 3'b100;
                            state_q    <= StDone;
                        end else begin
`ifdef FP32_SUB_ROUND_NEAREST_EN
                            man_q   <= {1'b0, man_q[24:1]};
                            grs_q   <= {man_q[0], grs_q[2], |grs_q[1:0]};
                            exp_q   <= exp_q + 8'd1;
                            state_q <= StRound;
`else
                            out_valid  <= 1'b1;
                            out_result <= {sign_q, exp_q + 8'd1, man_q[23:1]};
                            out_flags  <= 3'b000;
                            state_q    <= StDone;
`endif
                        end
                    end else if (man_q[23]) begin
`ifdef FP32_SUB_ROUND_NEAREST_EN
                        state_q <= StRound;
`else
                        out_valid  <= 1'b1;
                        out_result <= {sign_q, exp_q, man_q[22:0]};
                        out_flags  <= 3'b000;
                        state_q    <= StDone;
`endif
                    end else if (exp_q <= {3'd0, shamt}) begin
                        // Would go denormal: flush to zero.
                        out_valid  <= 1'b1;
                        out_result <= 32'd0;
                        out_flags  <= 3'b011;
                        state_q    <= StDone;
                    end else begin
                        man_q <= shl[26:2];
                        grs_q <= {shl[1:0], grs_q[0]};
                        exp_q <= exp_q - {3'd0, shamt};
                    end
                end
`ifdef FP32_SUB_ROUND_NEAREST_EN
                StRound: begin
                    out_valid <= 1'b1;
                    state_q   <= StDone;
                    if (rnd_frac[23]) begin
                        if (exp_q == 8'hFE) begin
                            out_result <= {sign_q, 8'hFF, 23'd0};
                            out_flags  <= 3'b100;
                        end else begin
                            out_result <= {sign_q, exp_q + 8'd1, 23'd0};
                            out_flags  <= 3'b000;
                        end
                    end else begin
                        out_result <= {sign_q, exp_q, rnd_frac[22:0]};
                        out_flags  <= 3'b000;
                    end
                end
`endif
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_sub_normalize_seq.sv
// Randomised + directed scoreboard bench for fp32_sub_normalize_seq.
module tb_fp32_sub_normalize_seq;
    parameter int unsigned SHIFT_STEP = 1;
    localparam int SS = SHIFT_STEP;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_man;
    logic [2:0]  in_grs;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    fp32_sub_normalize_seq #(.SHIFT_STEP(SHIFT_STEP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_man     (in_man),
        .in_grs     (in_grs),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flags;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [24:0] m;
        logic [2:0]  grs;
        logic [31:0] res;
        logic [2:0]  fl;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   hold_low = 1'b0;

`ifdef FP32_SUB_ROUND_NEAREST_EN
    localparam logic [31:0] RND_CASE = 32'h4000_0000;
    localparam logic [31:0] TIE_CASE = 32'h4000_0002;
`else
    localparam logic [31:0] RND_CASE = 32'h3FFF_FFFF;
    localparam logic [31:0] TIE_CASE = 32'h4000_0001;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Value-level model: find how far the leading one must move, then round the 24-bit significand.
    function automatic exp_t model(input logic s, input int e, input logic [24:0] m,
                                   input logic [2:0] grs);
        exp_t        x;
        logic [25:0] v;
        logic [25:0] w;
        logic [23:0] sig;
        logic        g;
        logic        rs;
        int          ex;
        int          sh;
        x.res = 32'd0; x.flags = 3'd0; x.lat = 0; x.acc = 0;
        if (e == 0) begin
            x.flags = {1'b0, (m != 25'd0), 1'b1};
            return x;
        end
        if (m == 25'd0 && grs == 3'd0) begin
            x.flags = 3'b001;
            x.lat   = 1;
            return x;
        end
        if (m[24]) begin
            ex    = e + 1;
            x.lat = 1;
            if (ex == 255) begin
                x.res   = {s, 8'hFF, 23'd0};
                x.flags = 3'b100;
                return x;
            end
            sig = m[24:1];
            g   = m[0];
            rs  = |grs;
        end else begin
            v  = {m[23:0], grs[2], grs[1]};
            sh = 1000;
            for (int i = 0; i < 26; i++) if (v[i]) sh = 25 - i;
            if (sh >= e) begin
                x.flags = 3'b011;
                x.lat   = (e + SS - 1) / SS;
                return x;
            end
            ex    = e - sh;
            w     = v << sh;
            sig   = w[25:2];
            g     = w[1];
            rs    = w[0] | grs[0];
            x.lat = (sh + SS - 1) / SS + 1;
        end
`ifdef FP32_SUB_ROUND_NEAREST_EN
        x.lat++;
        if (g && (rs || sig[0])) begin
            if (sig == 24'hFF_FFFF) begin
                ex++;
                sig = 24'h80_0000;
                if (ex == 255) begin
                    x.res   = {s, 8'hFF, 23'd0};
                    x.flags = 3'b100;
                    return x;
                end
            end else begin
                sig = sig + 24'd1;
            end
        end
`endif
        x.res = {s, ex[7:0], sig[22:0]};
        return x;
    endfunction

    task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m,
                        input logic [2:0] grs, input logic [31:0] res, input logic [2:0] fl,
                        input bit push);
        exp_t x;
        int   t;
        x       = model(s, int'(e), m, grs);
        x.res   = res;
        x.flags = fl;
        @(negedge clk);
        in_sign  = s;
        in_exp   = e;
        in_man   = m;
        in_grs   = grs;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready got %b want 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        x.acc = cyc + 1;
        if (push) sb.push_back(x);
        @(negedge clk);
        in_valid = 1'b0;
        in_sign  = 1'($urandom);
        in_exp   = 8'($urandom);
        in_man   = 25'($urandom);
        in_grs   = 3'($urandom);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(in_ready && sb.size() == 0 && !out_valid) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: pending %0d want 0", sb.size());
        end
    endtask

    // Monitor: pops the scoreboard on the first cycle of each result, then checks it holds.
    exp_t        mon_e;
    bit          holding = 1'b0;
    logic [31:0] held_res;
    logic [2:0]  held_fl;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
                if (!holding) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_output: got %h want no output", out_result);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("result", out_result, mon_e.res);
                        chk("flags", {29'd0, out_flags}, {29'd0, mon_e.flags});
                        chk("latency", cyc - mon_e.acc, mon_e.lat);
                    end
                    held_res = out_result;
                    held_fl  = out_flags;
                    holding  = 1'b1;
                end else begin
                    chk("stable_result", out_result, held_res);
                    chk("stable_flags", {29'd0, out_flags}, {29'd0, held_fl});
                end
            end else begin
                holding = 1'b0;
            end
        end else begin
            holding = 1'b0;
        end
        out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    vec_t dir[$];
    exp_t rx;

    initial begin
        logic        s;
        logic [7:0]  e;
        logic [24:0] m;
        logic [2:0]  g;
        logic [25:0] mk;
        int          k;
        int          t;

        in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'd0; in_man = 25'd0; in_grs = 3'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_flags", {29'd0, out_flags}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        dir.push_back(vec_t'{1'b0, 8'h80, 25'h080_0000, 3'b000, 32'h4000_0000, 3'b000});
        dir.push_back(vec_t'{1'b0, 8'h80, 25'h000_0001, 3'b000, 32'h3480_0000, 3'b000});
        dir.push_back(vec_t'{1'b1, 8'h80, 25'h000_0000, 3'b000, 32'h0000_0000, 3'b001});
        dir.push_back(vec_t'{1'b0, 8'h05, 25'h000_0001, 3'b000, 32'h0000_0000, 3'b011});
        dir.push_back(vec_t'{1'b0, 8'hFE, 25'h100_0000, 3'b000, 32'h7F80_0000, 3'b100});
        dir.push_back(vec_t'{1'b0, 8'h7F, 25'h0FF_FFFF, 3'b100, RND_CASE, 3'b000});
        dir.push_back(vec_t'{1'b0, 8'h80, 25'h080_0001, 3'b100, TIE_CASE, 3'b000});
        dir.push_back(vec_t'{1'b1, 8'h80, 25'h080_0000, 3'b100, 32'hC000_0000, 3'b000});
        dir.push_back(vec_t'{1'b0, 8'h00, 25'h000_0123, 3'b000, 32'h0000_0000, 3'b011});
        dir.push_back(vec_t'{1'b1, 8'h00, 25'h000_0000, 3'b000, 32'h0000_0000, 3'b001});
        foreach (dir[i]) send(dir[i].s, dir[i].e, dir[i].m, dir[i].grs, dir[i].res, dir[i].fl, 1'b1);

        // Backpressure: hold the result for five cycles.
        wait_idle();
        hold_low = 1'b1;
        @(negedge clk);
        send(1'b0, 8'h80, 25'h080_0000, 3'b000, 32'h4000_0000, 3'b000, 1'b1);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
        hold_low = 1'b0;

        // Abort mid-normalisation, then confirm the next operation is clean.
        wait_idle();
        send(1'b0, 8'h80, 25'h000_0001, 3'b000, 32'd0, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_out_result", out_result, 32'd0);
        chk("abort_out_flags", {29'd0, out_flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b0, 8'h80, 25'h080_0000, 3'b000, 32'h4000_0000, 3'b000, 1'b1);

        for (int n = 0; n < 150; n++) begin
            s = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       e = 8'($urandom_range(1, 30));
                1:       e = 8'($urandom_range(230, 254));
                default: e = 8'($urandom_range(31, 229));
            endcase
            if ($urandom_range(0, 19) == 0) e = 8'd0;
            k  = $urandom_range(0, 25);
            mk = (26'd1 << k) - 26'd1;
            m  = 25'($urandom) & mk[24:0];
            if (k > 0) m[k-1] = 1'b1;
            g  = 3'($urandom);
            rx = model(s, int'(e), m, g);
            send(s, e, m, g, rx.res, rx.flags, 1'b1);
        end

        wait_idle();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
